arb4_rr: RTL

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_rr.sv | 114 +++++++++++
 1 files changed

// File: rtl/arb4_rr.sv
// rtl/arb4_rr.sv - four-source round-robin arbiter with shared 4:1 data select (option macro: ARB4_RR_LOCK_EN adds the lock input for bursts)
module arb4_rr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             out_ready,
`ifdef ARB4_RR_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, sel_n;
  logic [3:0] gnt_n;
  logic       transfer;
  logic       hold_burst;
  logic [2:0] idle_hit;
  logic [2:0] next_hit;
  logic [1:0] sel_inc;

  // Returns {found, index} of the first requester scanning base, base+1, ... mod 4.
  // Iterating from the far end down lets the nearest hit overwrite the others.
  function automatic logic [2:0] search(input logic [1:0] base, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign sel_inc  = sel + 2'd1;
  assign idle_hit = search(ptr, req);
  assign next_hit = search(sel_inc, req);

`ifdef ARB4_RR_LOCK_EN
  assign hold_burst = lock[sel] & req[sel];
`else
  assign hold_burst = 1'b0;
`endif

  // Handshake and shared data path: purely combinational so source changes show up immediately.
  always_comb begin
    out_valid = (state == GRANT) && req[sel];
    transfer  = out_valid && out_ready;
    case (sel)
      2'd0:    out_data = A;
      2'd1:    out_data = B;
      2'd2:    out_data = C;
      default: out_data = D;
    endcase
  end

  // Next-state: grant from ptr when idle; on a transfer rotate past the winner; abort if the request drops.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    case (state)
      IDLE: begin
        if (idle_hit[2]) begin
          state_n = GRANT;
          sel_n   = idle_hit[1:0];
        end
      end
      GRANT: begin
        if (transfer) begin
          if (!hold_burst) begin
            ptr_n = sel_inc;
            if (next_hit[2]) begin
              sel_n = next_hit[1:0];
            end else begin
              state_n = IDLE;
            end
          end
        end else if (!req[sel]) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    gnt_n = (state_n == GRANT) ? (4'b0001 << sel_n) : 4'b0000;
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
    end
  end

endmodule
